// File: rtl/ps2_defs.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_defs (package)
//  Description : Shared constants for the PS/2 mouse receiver: frame size,
//                movement-packet byte-0 bit positions, and FSM encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_defs;

    // Start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    // Byte-0 bit positions of a standard 3-byte movement packet
    localparam int SYNC_BIT = 3;
    localparam int XSIGN    = 4;
    localparam int YSIGN    = 5;
    localparam int XOVF     = 6;
    localparam int YOVF     = 7;
    localparam int BTN_LSB  = 0;

    // Frame deframer states
    localparam logic [1:0] FRM_IDLE   = 2'd0;
    localparam logic [1:0] FRM_DATA   = 2'd1;
    localparam logic [1:0] FRM_PARITY = 2'd2;
    localparam logic [1:0] FRM_STOP   = 2'd3;

    // Packet assembler states
    localparam logic [1:0] PKT_B0 = 2'd0;
    localparam logic [1:0] PKT_B1 = 2'd1;
    localparam logic [1:0] PKT_B2 = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_frame_rx
//  Description : Synchronizes and filters the raw PS/2 lines, detects falling
//                edges of the filtered clock and deframes 11-bit
//                device-to-host frames into bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import ps2_defs::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic       i_abort,
    output logic       o_fall,
    output logic       o_idle,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_err
);

    localparam int c_cnt_w     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int c_data_bits = FRAME_BITS - 3;

    logic               r_clk_meta;
    logic               r_clk_sync;
    logic               r_data_meta;
    logic               r_data_sync;
    logic [c_cnt_w-1:0] r_filt_cnt;
    logic               r_filt_clk;
    logic               r_fall;
    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic               r_par_ok;

    // Two-flop synchronizers; idle bus level is high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= i_ps2_clk;
            r_clk_sync  <= r_clk_meta;
            r_data_meta <= i_ps2_data;
            r_data_sync <= r_data_meta;
        end
    end

    // Clock filter: flip only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_sync == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_cnt_w'(FILTER_LEN - 1)) begin
                r_filt_clk <= r_clk_sync;
                r_filt_cnt <= '0;
                // Filtered clock currently high and about to go low
                r_fall     <= r_filt_clk;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FRM_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame next-state logic; an abort forces the deframer back to idle
    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = FRM_IDLE;
        end else if (r_fall) begin
            case (r_state)
                FRM_IDLE:   if (!r_data_sync) w_next = FRM_DATA;
                FRM_DATA:   if (r_bit_cnt == 3'(c_data_bits - 1)) w_next = FRM_PARITY;
                FRM_PARITY: w_next = FRM_STOP;
                FRM_STOP:   w_next = FRM_IDLE;
                default:    w_next = FRM_IDLE;
            endcase
        end
    end

    // Frame outputs: byte or error is reported on the fall that samples it
    always_comb begin
        o_byte_valid = 1'b0;
        o_err        = 1'b0;
        if (r_fall && !i_abort) begin
            case (r_state)
                FRM_IDLE: o_err = r_data_sync;
                FRM_STOP: begin
                    if (r_data_sync && r_par_ok) o_byte_valid = 1'b1;
                    else                         o_err        = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Shift register, bit counter and odd-parity evaluation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_ok  <= 1'b0;
        end else if (r_fall) begin
            case (r_state)
                FRM_IDLE: r_bit_cnt <= '0;
                FRM_DATA: begin
                    r_shift   <= {r_data_sync, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                FRM_PARITY: r_par_ok <= ^{r_shift, r_data_sync};
                default: ;
            endcase
        end
    end

    assign o_fall = r_fall;
    assign o_idle = (r_state == FRM_IDLE);
    assign o_byte = r_shift;

endmodule
`default_nettype wire

// File: rtl/ps2_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_packet_rx
//  Description : Host-side PS/2 mouse receiver. Assembles 3-byte movement
//                packets into 9-bit X/Y deltas, buttons and overflow flags,
//                with a one-cycle packet strobe and an error strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_packet_rx
    import ps2_defs::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [8:0] x_axis,
    output logic [8:0] y_axis,
    output logic [2:0] buttons,
    output logic [1:0] overflow,
    output logic       pkt_valid,
    output logic       frame_err
);

    localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);

    logic              w_fall;
    logic              w_frm_idle;
    logic              w_byte_valid;
    logic [7:0]        w_byte;
    logic              w_frm_err;
    logic              w_timeout;
    logic              w_to_active;
    logic [c_to_w-1:0] r_to_cnt;

    logic [1:0]        r_pkt_state;
    logic [1:0]        w_pkt_next;
    logic              w_take_b0;
    logic              w_take_b1;
    logic              w_pkt_done;
    logic              w_sync_err;

    logic [2:0]        r_btn;
    logic              r_xsign;
    logic              r_ysign;
    logic [1:0]        r_ovf;
    logic [7:0]        r_xlo;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN)
    ) u_frame (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .i_abort      (w_timeout),
        .o_fall       (w_fall),
        .o_idle       (w_frm_idle),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_err        (w_frm_err)
    );

    // Timeout runs only while a frame or packet is in progress; a fall wins
    assign w_to_active = !w_frm_idle || (r_pkt_state != PKT_B0);
    assign w_timeout   = w_to_active && !w_fall &&
                         (r_to_cnt == c_to_w'(TIMEOUT_CYCLES - 1));

    // Timeout counter: cleared by every fall, by idling, and on expiry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_fall || !w_to_active || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Packet state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pkt_state <= PKT_B0;
        end else begin
            r_pkt_state <= w_pkt_next;
        end
    end

    // Packet next-state logic; any error resynchronizes to byte 0
    always_comb begin
        w_pkt_next = r_pkt_state;
        if (w_timeout || w_frm_err) begin
            w_pkt_next = PKT_B0;
        end else if (w_byte_valid) begin
            case (r_pkt_state)
                PKT_B0:  if (w_byte[SYNC_BIT]) w_pkt_next = PKT_B1;
                PKT_B1:  w_pkt_next = PKT_B2;
                PKT_B2:  w_pkt_next = PKT_B0;
                default: w_pkt_next = PKT_B0;
            endcase
        end
    end

    // Packet decode strobes
    always_comb begin
        w_take_b0  = w_byte_valid && (r_pkt_state == PKT_B0) && w_byte[SYNC_BIT];
        w_sync_err = w_byte_valid && (r_pkt_state == PKT_B0) && !w_byte[SYNC_BIT];
        w_take_b1  = w_byte_valid && (r_pkt_state == PKT_B1);
        w_pkt_done = w_byte_valid && (r_pkt_state == PKT_B2);
    end

    // Partial-packet holding registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btn   <= '0;
            r_xsign <= 1'b0;
            r_ysign <= 1'b0;
            r_ovf   <= '0;
            r_xlo   <= '0;
        end else begin
            if (w_take_b0) begin
                r_btn   <= w_byte[BTN_LSB +: 3];
                r_xsign <= w_byte[XSIGN];
                r_ysign <= w_byte[YSIGN];
                r_ovf   <= {w_byte[YOVF], w_byte[XOVF]};
            end
            if (w_take_b1) begin
                r_xlo <= w_byte;
            end
        end
    end

    // Output registers: updated together only when a packet completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_axis    <= '0;
            y_axis    <= '0;
            buttons   <= '0;
            overflow  <= '0;
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            pkt_valid <= w_pkt_done;
            frame_err <= w_frm_err || w_sync_err || w_timeout;
            if (w_pkt_done) begin
                x_axis   <= {r_xsign, r_xlo};
                y_axis   <= {r_ysign, w_byte};
                buttons  <= r_btn;
                overflow <= r_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_packet_rx
//  Description : Self-checking bench for ps2_packet_rx. A PS/2 device model
//                drives frames; expected packets are queued and compared as
//                the receiver strobes pkt_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_packet_rx;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 20000;
    localparam int HALF           = 30;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic [2:0] b;
        logic [1:0] o;
    } pkt_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [8:0] x_axis;
    logic [8:0] y_axis;
    logic [2:0] buttons;
    logic [1:0] overflow;
    logic       pkt_valid;
    logic       frame_err;

    pkt_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_err_pulses = 0;

    ps2_packet_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .x_axis    (x_axis),
        .y_axis    (y_axis),
        .buttons   (buttons),
        .overflow  (overflow),
        .pkt_valid (pkt_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Output monitor: counts error pulses and scores each packet strobe
    task automatic run_monitor();
        pkt_t e;
        pkt_t got;
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) n_err_pulses++;
            if (pkt_valid === 1'b1) begin
                n_checks++;
                got = {x_axis, y_axis, buttons, overflow};
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL pkt_unexpected: got x=%h y=%h b=%b o=%b, required no packet",
                             x_axis, y_axis, buttons, overflow);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        n_errors++;
                        $display("FAIL pkt_fields: got x=%h y=%h b=%b o=%b, required x=%h y=%h b=%b o=%b",
                                 x_axis, y_axis, buttons, overflow, e.x, e.y, e.b, e.o);
                    end
                end
            end
        end
    endtask

    // Device-side frame: data changes while clock is high, host samples on fall
    task automatic send_frame(input logic [7:0] d, input bit bad_par,
                              input int n_bits, input int glitch_bit);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < n_bits; i++) begin
            ps2_data = f[i];
            if (i == glitch_bit) begin
                repeat (10) @(posedge clk);
                ps2_clk = 1'b0;
                repeat (FILTER_LEN - 1) @(posedge clk);
                ps2_clk = 1'b1;
                repeat (HALF - 10 - (FILTER_LEN - 1)) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2);
        send_frame(b0, 1'b0, 11, -1);
        send_frame(b1, 1'b0, 11, -1);
        send_frame(b2, 1'b0, 11, -1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (x_axis !== 9'd0)   begin n_errors++; $display("FAIL reset_x: got %h required 000", x_axis); end
        n_checks++; if (y_axis !== 9'd0)   begin n_errors++; $display("FAIL reset_y: got %h required 000", y_axis); end
        n_checks++; if (buttons !== 3'd0)  begin n_errors++; $display("FAIL reset_buttons: got %b required 000", buttons); end
        n_checks++; if (overflow !== 2'd0) begin n_errors++; $display("FAIL reset_overflow: got %b required 00", overflow); end
        n_checks++; if (pkt_valid !== 1'b0) begin n_errors++; $display("FAIL reset_pkt_valid: got %b required 0", pkt_valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
    endtask

    // Sends one good packet and checks it was consumed with no error pulse
    task automatic test_packet(input string name, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2,
                               input pkt_t exp);
        int e0;
        e0 = n_err_pulses;
        sb.push_back(exp);
        send_packet(b0, b1, b2);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL %s_pending: got %0d queued, required 0", name, sb.size()); end
        n_checks++;
        if (n_err_pulses != e0) begin n_errors++; $display("FAIL %s_err: got %0d pulses, required 0", name, n_err_pulses - e0); end
    endtask

    task automatic test_parity_err();
        int e0;
        e0 = n_err_pulses;
        send_frame(8'h08, 1'b0, 11, -1);
        send_frame(8'h10, 1'b1, 11, -1);
        sb.push_back(pkt_t'{9'h001, 9'h002, 3'd0, 2'd0});
        send_packet(8'h08, 8'h01, 8'h02);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (n_err_pulses - e0 != 1) begin n_errors++; $display("FAIL parity_err: got %0d pulses, required 1", n_err_pulses - e0); end
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL parity_pending: got %0d queued, required 0", sb.size()); end
    endtask

    task automatic test_sync_err();
        int e0;
        e0 = n_err_pulses;
        send_frame(8'h00, 1'b0, 11, -1);
        sb.push_back(pkt_t'{9'h003, 9'h004, 3'd0, 2'd0});
        send_packet(8'h08, 8'h03, 8'h04);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (n_err_pulses - e0 != 1) begin n_errors++; $display("FAIL sync_err: got %0d pulses, required 1", n_err_pulses - e0); end
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL sync_pending: got %0d queued, required 0", sb.size()); end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = n_err_pulses;
        send_frame(8'h08, 1'b0, 11, -1);
        send_frame(8'h05, 1'b0, 11, -1);
        repeat (TIMEOUT_CYCLES + 50) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (n_err_pulses - e0 != 1) begin n_errors++; $display("FAIL timeout_err: got %0d pulses, required 1", n_err_pulses - e0); end
        e0 = n_err_pulses;
        sb.push_back(pkt_t'{9'h006, 9'h007, 3'd0, 2'd0});
        send_packet(8'h08, 8'h06, 8'h07);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL timeout_pending: got %0d queued, required 0", sb.size()); end
        n_checks++;
        if (n_err_pulses != e0) begin n_errors++; $display("FAIL timeout_after_err: got %0d pulses, required 0", n_err_pulses - e0); end
    endtask

    task automatic test_glitch();
        int e0;
        e0 = n_err_pulses;
        sb.push_back(pkt_t'{9'h00A, 9'h00B, 3'd0, 2'd0});
        send_frame(8'h08, 1'b0, 11, -1);
        send_frame(8'h0A, 1'b0, 11, 3);
        send_frame(8'h0B, 1'b0, 11, -1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL glitch_pending: got %0d queued, required 0", sb.size()); end
        n_checks++;
        if (n_err_pulses != e0) begin n_errors++; $display("FAIL glitch_err: got %0d pulses, required 0", n_err_pulses - e0); end
    endtask

    task automatic test_back_to_back();
        int e0;
        e0 = n_err_pulses;
        sb.push_back(pkt_t'{9'h011, 9'h122, 3'b010, 2'd0});
        sb.push_back(pkt_t'{9'h133, 9'h044, 3'b100, 2'd0});
        send_packet(8'h2A, 8'h11, 8'h22);
        send_packet(8'h1C, 8'h33, 8'h44);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL b2b_pending: got %0d queued, required 0", sb.size()); end
        n_checks++;
        if (n_err_pulses != e0) begin n_errors++; $display("FAIL b2b_err: got %0d pulses, required 0", n_err_pulses - e0); end
    endtask

    task automatic test_reset_mid();
        int e0;
        e0 = n_err_pulses;
        send_frame(8'h09, 1'b0, 11, -1);
        send_frame(8'h0C, 1'b0, 5, -1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (n_err_pulses != e0) begin n_errors++; $display("FAIL rstmid_err: got %0d pulses, required 0", n_err_pulses - e0); end
        n_checks++;
        if ({x_axis, y_axis, buttons, overflow} !== 23'd0) begin
            n_errors++;
            $display("FAIL rstmid_outputs: got x=%h y=%h b=%b o=%b, required all 0", x_axis, y_axis, buttons, overflow);
        end
        test_packet("rstmid_next", 8'h08, 8'h0C, 8'h0D, pkt_t'{9'h00C, 9'h00D, 3'd0, 2'd0});
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_packet("basic", 8'h18, 8'h05, 8'hFB, pkt_t'{9'h105, 9'h0FB, 3'd0, 2'd0});
        test_packet("buttons", 8'h09, 8'h7F, 8'h00, pkt_t'{9'h07F, 9'h000, 3'b001, 2'd0});
        test_packet("overflow", 8'hCF, 8'h80, 8'h81, pkt_t'{9'h080, 9'h081, 3'b111, 2'b11});
        test_packet("signs", 8'h38, 8'h05, 8'hFB, pkt_t'{9'h105, 9'h1FB, 3'd0, 2'd0});
        test_parity_err();
        test_sync_err();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
